// File: rtl/wave_ctrl_if.sv
// Control/status bundle between the command path, the rate generator and the
// waveform datapath (var_clk + memory) driven by wave_ctrl.
interface wave_ctrl_if;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       sample_tick;
  logic [3:0] selector;
  logic       dp_rst;
  logic       mute;
  logic       busy;
  logic       cmd_err;
  logic       overrun;

  modport master (
    output cmd, cmd_valid, sample_tick,
    input  selector, dp_rst, mute, busy, cmd_err, overrun
  );

  modport slave (
    input  cmd, cmd_valid, sample_tick,
    output selector, dp_rst, mute, busy, cmd_err, overrun
  );
endinterface

// File: rtl/wave_ctrl.sv
// Waveform reconfiguration sequencer: waits for a sample boundary, pulses the
// datapath reset with the new selector, then keeps the DAC muted while it settles.
module wave_ctrl #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned SETTLE_TICKS = 2,
  parameter int unsigned TICK_TIMEOUT = 1024,
  parameter logic [3:0]  MAX_SEL      = 4'd7
) (
  input logic        clk,
  input logic        rst,
  wave_ctrl_if.slave bus
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
  localparam int unsigned SCW = $clog2(SETTLE_TICKS + 1);
  localparam int unsigned TCW = $clog2(TICK_TIMEOUT + 1);
  localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_TICKS - 1);
  localparam logic [TCW-1:0] TO_LAST     = TCW'(TICK_TIMEOUT - 1);

  localparam logic [3:0] OP_SET    = 4'h0;
  localparam logic [3:0] OP_MUTE   = 4'h1;
  localparam logic [3:0] OP_UNMUTE = 4'h2;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, RESET, SETTLE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     sel_q, sel_d;
  logic [3:0]     target_q, target_d;
  logic [3:0]     pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic           dp_rst_q, dp_rst_d;
  logic           user_mute_q, user_mute_d;
  logic           mute_q, mute_d;
  logic           cmd_err_q, cmd_err_d;
  logic           overrun_q, overrun_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;

  logic [3:0] op;
  logic [3:0] arg;
  logic       set_ok;

  assign op     = bus.cmd[3:0];
  assign arg    = bus.cmd[7:4];
  assign set_ok = bus.cmd_valid && (op == OP_SET) && (arg <= MAX_SEL);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    target_d     = target_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    dp_rst_d     = dp_rst_q;
    user_mute_d  = user_mute_q;
    rst_cnt_d    = rst_cnt_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    overrun_d    = 1'b0;
    cmd_err_d    = bus.cmd_valid &&
                   ((op > OP_UNMUTE) || ((op == OP_SET) && (arg > MAX_SEL)));

    if (bus.cmd_valid && (op == OP_MUTE))   user_mute_d = 1'b1;
    if (bus.cmd_valid && (op == OP_UNMUTE)) user_mute_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh SET outranks a pending one; the older pending request is dropped.
        if (set_ok) begin
          target_d = arg;
          state_d  = WAIT_TICK;
          to_cnt_d = '0;
          if (pend_valid_q) begin
            pend_valid_d = 1'b0;
            overrun_d    = 1'b1;
          end
        end else if (pend_valid_q) begin
          target_d     = pend_q;
          pend_valid_d = 1'b0;
          state_d      = WAIT_TICK;
          to_cnt_d     = '0;
        end
      end
      WAIT_TICK: begin
        if (bus.sample_tick || (to_cnt_q == TO_LAST)) begin
          state_d   = RESET;
          sel_d     = target_q;
          dp_rst_d  = 1'b1;
          rst_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TCW'(1);
        end
      end
      RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d      = SETTLE;
          dp_rst_d     = 1'b0;
          settle_cnt_d = '0;
          to_cnt_d     = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      SETTLE: begin
        // Timeout measures the gap since the last tick, not total settle time.
        if (bus.sample_tick) begin
          to_cnt_d = '0;
          if (settle_cnt_q == SETTLE_LAST) state_d = IDLE;
          else settle_cnt_d = settle_cnt_q + SCW'(1);
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TCW'(1);
        end
      end
      default: state_d = RESET;
    endcase

    if ((state_q != IDLE) && set_ok) begin
      pend_d       = arg;
      pend_valid_d = 1'b1;
      overrun_d    = pend_valid_q;
    end

    mute_d = user_mute_d | (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET;
      sel_q        <= '0;
      target_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      dp_rst_q     <= 1'b1;
      user_mute_q  <= 1'b0;
      mute_q       <= 1'b1;
      cmd_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      target_q     <= target_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      dp_rst_q     <= dp_rst_d;
      user_mute_q  <= user_mute_d;
      mute_q       <= mute_d;
      cmd_err_q    <= cmd_err_d;
      overrun_q    <= overrun_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign bus.selector = sel_q;
  assign bus.dp_rst   = dp_rst_q;
  assign bus.mute     = mute_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.cmd_err  = cmd_err_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_wave_ctrl.sv
// Scenario bench for wave_ctrl: every datapath reset pops an expected selector
// from a scoreboard filled when the corresponding SET is driven.
module tb_wave_ctrl;
  logic clk = 1'b0;
  logic rst;

  wave_ctrl_if bus ();

  wave_ctrl #(
    .RST_CYCLES  (2),
    .SETTLE_TICKS(1),
    .TICK_TIMEOUT(8),
    .MAX_SEL     (4'd7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_sel_q[$];
  int   mon_exp;
  logic dp_rst_prev = 1'b1;
  bit   auto_tick   = 1'b0;
  int   tick_phase  = 0;

  // Scoreboard consumer: each rising dp_rst must carry the next expected selector.
  always @(negedge clk) begin
    if (bus.dp_rst === 1'b1 && dp_rst_prev === 1'b0) begin
      n_checks++;
      if (exp_sel_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_reseq: got selector=%0d, required no datapath reset", bus.selector);
      end else begin
        mon_exp = exp_sel_q.pop_front();
        if (bus.selector !== mon_exp[3:0]) begin
          n_fail++;
          $display("FAIL sb_selector: got %0d, required %0d", bus.selector, mon_exp);
        end else begin
          $display("reseq selector=%0d ok", bus.selector);
        end
      end
    end
    dp_rst_prev = bus.dp_rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.cmd_valid   = 1'b0;
    bus.sample_tick = 1'b0;
    if (auto_tick) begin
      tick_phase++;
      if (tick_phase >= 4) begin
        tick_phase      = 0;
        bus.sample_tick = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] c);
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    $display("cmd 0x%02h", c);
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1;
    next_cycle();
    send(8'h01);
    next_cycle();
    n_checks++;
    if ({bus.selector, bus.dp_rst, bus.mute, bus.busy, bus.cmd_err, bus.overrun} !== 9'b0000_1_1_1_0_0) begin
      n_fail++;
      $display("FAIL reset_state: got sel=%0d dp_rst=%b mute=%b busy=%b err=%b ovr=%b, required 0 1 1 1 0 0",
               bus.selector, bus.dp_rst, bus.mute, bus.busy, bus.cmd_err, bus.overrun);
    end
    auto_tick = 1'b1;
    rst = 1'b0;
    k = 0;
    while (bus.dp_rst === 1'b1 && k < 10) begin next_cycle(); k++; end
    n_checks++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL reset_dp_rst_len: got %0d cycles, required 2", k);
    end
    k = 0;
    while (bus.busy !== 1'b0 && k < 20) begin next_cycle(); k++; end
    n_checks++;
    if (k < 1 || k > 4) begin
      n_fail++;
      $display("FAIL reset_settle_len: got %0d cycles, required 1..4", k);
    end
    n_checks++;
    if (bus.mute !== 1'b0 || bus.selector !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got mute=%b sel=%0d, required mute=0 sel=0", bus.mute, bus.selector);
    end
    $display("test_reset done");
    auto_tick = 1'b0;
    next_cycle();
  endtask

  task automatic test_set();
    send(8'h30);
    exp_sel_q.push_back(3);
    next_cycle();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mute !== 1'b1) begin
      n_fail++;
      $display("FAIL set_busy: got busy=%b mute=%b, required 1 1", bus.busy, bus.mute);
    end
    next_cycle();
    next_cycle();
    bus.sample_tick = 1'b1;
    next_cycle();
    n_checks++;
    if (bus.selector !== 4'd3 || bus.dp_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL set_enter_reset: got sel=%0d dp_rst=%b, required 3 1", bus.selector, bus.dp_rst);
    end
    next_cycle();
    n_checks++;
    if (bus.dp_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL set_dp_rst_hold: got %b, required 1", bus.dp_rst);
    end
    next_cycle();
    n_checks++;
    if (bus.dp_rst !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL set_settle: got dp_rst=%b busy=%b, required 0 1", bus.dp_rst, bus.busy);
    end
    bus.sample_tick = 1'b1;
    next_cycle();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mute !== 1'b0) begin
      n_fail++;
      $display("FAIL set_idle: got busy=%b mute=%b, required 0 0", bus.busy, bus.mute);
    end
    $display("test_set done");
  endtask

  task automatic test_errors();
    logic [7:0] bad [3];
    bad[0] = 8'h90;
    bad[1] = 8'h05;
    bad[2] = 8'hF3;
    for (int i = 0; i < 3; i++) begin
      send(bad[i]);
      next_cycle();
      n_checks++;
      if (bus.cmd_err !== 1'b1 || bus.overrun !== 1'b0 || bus.busy !== 1'b0 || bus.selector !== 4'd3) begin
        n_fail++;
        $display("FAIL err_pulse_%02h: got err=%b ovr=%b busy=%b sel=%0d, required 1 0 0 3",
                 bad[i], bus.cmd_err, bus.overrun, bus.busy, bus.selector);
      end
      next_cycle();
      n_checks++;
      if (bus.cmd_err !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clear_%02h: got err=%b busy=%b, required 0 0", bad[i], bus.cmd_err, bus.busy);
      end
    end
    $display("test_errors done");
  endtask

  task automatic test_overrun();
    int k;
    send(8'h60);
    exp_sel_q.push_back(6);
    next_cycle();
    send(8'h10);
    next_cycle();
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first_queued: got %b, required 0", bus.overrun);
    end
    send(8'h20);
    exp_sel_q.push_back(2);
    next_cycle();
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pulse: got ovr=%b err=%b, required 1 0", bus.overrun, bus.cmd_err);
    end
    next_cycle();
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: got %b, required 0", bus.overrun);
    end
    auto_tick = 1'b1;
    k = 0;
    while ((bus.busy !== 1'b0 || exp_sel_q.size() != 0) && k < 100) begin next_cycle(); k++; end
    n_checks++;
    if (bus.busy !== 1'b0 || exp_sel_q.size() != 0 || bus.selector !== 4'd2) begin
      n_fail++;
      $display("FAIL ovr_final: got busy=%b left=%0d sel=%0d, required 0 0 2",
               bus.busy, exp_sel_q.size(), bus.selector);
    end
    auto_tick = 1'b0;
    $display("test_overrun done");
    next_cycle();
  endtask

  task automatic test_timeout();
    int k;
    send(8'h40);
    exp_sel_q.push_back(4);
    next_cycle();
    k = 0;
    while (bus.dp_rst !== 1'b1 && k < 20) begin next_cycle(); k++; end
    n_checks++;
    if (k != 8 || bus.selector !== 4'd4) begin
      n_fail++;
      $display("FAIL to_wait: got %0d cycles sel=%0d, required 8 cycles sel=4", k, bus.selector);
    end
    k = 0;
    while (bus.dp_rst !== 1'b0 && k < 10) begin next_cycle(); k++; end
    n_checks++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL to_dp_rst_len: got %0d, required 2", k);
    end
    k = 0;
    while (bus.busy !== 1'b0 && k < 20) begin next_cycle(); k++; end
    n_checks++;
    if (k != 8) begin
      n_fail++;
      $display("FAIL to_settle: got %0d cycles, required 8", k);
    end
    $display("test_timeout done");
  endtask

  task automatic test_mute();
    int k;
    int bad;
    send(8'h01);
    next_cycle();
    n_checks++;
    if (bus.mute !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_user: got mute=%b busy=%b, required 1 0", bus.mute, bus.busy);
    end
    send(8'h50);
    exp_sel_q.push_back(5);
    next_cycle();
    send(8'h02);
    next_cycle();
    n_checks++;
    if (bus.mute !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_seq_hold: got mute=%b busy=%b, required 1 1", bus.mute, bus.busy);
    end
    auto_tick = 1'b1;
    k = 0;
    bad = 0;
    while (bus.busy !== 1'b0 && k < 40) begin
      next_cycle();
      k++;
      if (bus.busy === 1'b1 && bus.mute !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || bus.busy !== 1'b0 || bus.mute !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_release: got unmuted_busy=%0d busy=%b mute=%b, required 0 0 0", bad, bus.busy, bus.mute);
    end
    auto_tick = 1'b0;
    $display("test_mute done");
    next_cycle();
  endtask

  task automatic test_rst_abort();
    int k;
    int busy_cnt;
    send(8'h70);
    exp_sel_q.push_back(7);
    next_cycle();
    send(8'h30);
    next_cycle();
    bus.sample_tick = 1'b1;
    next_cycle();
    n_checks++;
    if (bus.selector !== 4'd7) begin
      n_fail++;
      $display("FAIL abort_pre: got sel=%0d, required 7", bus.selector);
    end
    rst = 1'b1;
    send(8'h50);
    next_cycle();
    n_checks++;
    if (bus.selector !== 4'd0 || bus.dp_rst !== 1'b1 || bus.busy !== 1'b1 || bus.mute !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got sel=%0d dp_rst=%b busy=%b mute=%b, required 0 1 1 1",
               bus.selector, bus.dp_rst, bus.busy, bus.mute);
    end
    next_cycle();
    rst = 1'b0;
    auto_tick = 1'b1;
    k = 0;
    while (bus.busy !== 1'b0 && k < 30) begin next_cycle(); k++; end
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (bus.busy !== 1'b0) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 0 || bus.selector !== 4'd0 || exp_sel_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_pending_lost: got busy_cycles=%0d sel=%0d left=%0d, required 0 0 0",
               busy_cnt, bus.selector, exp_sel_q.size());
    end
    auto_tick = 1'b0;
    $display("test_rst_abort done");
  endtask

  task automatic test_back_to_back();
    int k;
    send(8'h00);
    exp_sel_q.push_back(0);
    next_cycle();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL same_sel_start: got busy=%b, required 1", bus.busy);
    end
    auto_tick = 1'b1;
    k = 0;
    while ((bus.busy !== 1'b0 || exp_sel_q.size() != 0) && k < 40) begin next_cycle(); k++; end
    n_checks++;
    if (bus.busy !== 1'b0 || exp_sel_q.size() != 0 || bus.selector !== 4'd0) begin
      n_fail++;
      $display("FAIL same_sel_done: got busy=%b left=%0d sel=%0d, required 0 0 0",
               bus.busy, exp_sel_q.size(), bus.selector);
    end
    auto_tick = 1'b0;
    $display("test_back_to_back done");
  endtask

  initial begin
    rst             = 1'b1;
    bus.cmd         = 8'h00;
    bus.cmd_valid   = 1'b0;
    bus.sample_tick = 1'b0;
    test_reset();
    test_set();
    test_errors();
    test_overrun();
    test_timeout();
    test_mute();
    test_rst_abort();
    test_back_to_back();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
